// File: rtl/vga_pkg.sv
// vga_pkg: shared screen geometry, VRAM address/colour types and fill FSM states.
// Revision 1.0
`default_nettype none

package vga_pkg;

  localparam int COLS       = 40;
  localparam int ROWS       = 30;
  localparam int VRAM_DEPTH = COLS * ROWS;
  localparam int ADDR_W     = 11;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [1:0]        color_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    WAIT_WIN = 2'd2,
    FINISH   = 2'd3
  } state_t;

  // y * cols as a sum of shifted copies of y; cols is a constant, so this folds to adders
  function automatic addr_t row_offset(input logic [4:0] y, input addr_t cols);
    addr_t acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (cols[i]) acc = acc + (addr_t'(y) << i);
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vblank_window_timer.sv
// vblank_window_timer: write window that stays open WINDOW_CYCLES clocks after each vsync pulse.
// Revision 1.0
`default_nettype none

module vblank_window_timer #(
  parameter int WINDOW_CYCLES = 16384
) (
  input  logic sys_clock,
  input  logic reset,
  input  logic vsync_ready,
  output logic window_open
);

  localparam int              CNT_W = $clog2(WINDOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (vsync_ready) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign window_open = (count != '0);

endmodule

`default_nettype wire

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: fills a screen-clipped rectangle of tiles in VRAM, one write per cycle,
// optionally only while the vertical-blank window is open. Revision 1.0
`default_nettype none

module rect_fill_engine #(
  parameter int COLS          = vga_pkg::COLS,
  parameter int ROWS          = vga_pkg::ROWS,
  parameter int WINDOW_CYCLES = 16384
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_x,
  input  logic [4:0]  cmd_y,
  input  logic [5:0]  cmd_w,
  input  logic [4:0]  cmd_h,
  input  logic [1:0]  cmd_color,
  input  logic        cmd_vblank_only,
  input  logic        vsync_ready,
  output logic        vram_we,
  output logic [10:0] vram_addr,
  output logic [1:0]  vram_data,
  output logic        busy,
  output logic        done
);

  import vga_pkg::*;

  localparam logic [6:0] COLS_X = 7'(COLS);
  localparam logic [5:0] ROWS_Y = 6'(ROWS);
  localparam addr_t      COLS_A = addr_t'(COLS);

  state_t     state;
  addr_t      base;
  logic [5:0] col;
  logic [4:0] row;
  logic [5:0] cw;
  logic [4:0] ch;
  color_t     color;
  logic       vb_only;
  logic       all_issued;
  logic       window_open;

  vblank_window_timer #(
    .WINDOW_CYCLES (WINDOW_CYCLES)
  ) u_window (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .vsync_ready (vsync_ready),
    .window_open (window_open)
  );

  // Clipped extent of the offered command
  logic [6:0] x_end;
  logic [5:0] y_end;
  logic [5:0] cw_new;
  logic [4:0] ch_new;
  logic       empty;

  always_comb begin
    x_end = {1'b0, cmd_x} + {1'b0, cmd_w};
    if (x_end > COLS_X) x_end = COLS_X;
    y_end = {1'b0, cmd_y} + {1'b0, cmd_h};
    if (y_end > ROWS_Y) y_end = ROWS_Y;
    empty  = ({1'b0, cmd_x} >= COLS_X) || ({1'b0, cmd_y} >= ROWS_Y) ||
             (cmd_w == 6'd0) || (cmd_h == 5'd0);
    cw_new = empty ? 6'd0 : 6'(x_end - {1'b0, cmd_x});
    ch_new = empty ? 5'd0 : 5'(y_end - {1'b0, cmd_y});
  end

  // In IDLE the next tile comes straight from the command so the first write lands at the handshake
  addr_t      p_base;
  logic [5:0] p_col;
  logic [4:0] p_row;
  logic [5:0] p_cw;
  logic [4:0] p_ch;
  color_t     p_color;
  logic       p_vb;

  always_comb begin
    if (state == IDLE) begin
      p_base  = row_offset(cmd_y, COLS_A) + addr_t'(cmd_x);
      p_col   = 6'd0;
      p_row   = 5'd0;
      p_cw    = cw_new;
      p_ch    = ch_new;
      p_color = cmd_color;
      p_vb    = cmd_vblank_only;
    end else begin
      p_base  = base;
      p_col   = col;
      p_row   = row;
      p_cw    = cw;
      p_ch    = ch;
      p_color = color;
      p_vb    = vb_only;
    end
  end

  logic  win_ok;
  logic  last_col;
  logic  last_row;
  logic  do_issue;
  addr_t tile_addr;

  assign win_ok    = window_open || !p_vb;
  assign last_col  = (p_col == p_cw - 6'd1);
  assign last_row  = (p_row == p_ch - 5'd1);
  assign tile_addr = p_base + addr_t'(p_col);

  always_comb begin
    do_issue = 1'b0;
    case (state)
      IDLE:     do_issue = cmd_valid && !empty && win_ok;
      FILL:     do_issue = !all_issued && win_ok;
      WAIT_WIN: do_issue = win_ok;
      default:  do_issue = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
      done       <= 1'b0;
      base       <= '0;
      col        <= '0;
      row        <= '0;
      cw         <= '0;
      ch         <= '0;
      color      <= '0;
      vb_only    <= 1'b0;
      all_issued <= 1'b0;
    end else begin
      vram_we <= 1'b0;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            color      <= cmd_color;
            vb_only    <= cmd_vblank_only;
            cw         <= cw_new;
            ch         <= ch_new;
            base       <= p_base;
            col        <= 6'd0;
            row        <= 5'd0;
            all_issued <= 1'b0;
            if (empty)       state <= FINISH;
            else if (win_ok) state <= FILL;
            else             state <= WAIT_WIN;
          end
        end
        FILL: begin
          if (all_issued) begin
            state <= FINISH;
            done  <= 1'b1;
          end else if (!win_ok) begin
            state <= WAIT_WIN;
          end
        end
        WAIT_WIN: begin
          if (win_ok) state <= FILL;
        end
        FINISH: begin
          // An empty command arrives here with done low and spends one extra cycle raising it
          if (done) state <= IDLE;
          else      done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (do_issue) begin
        vram_we    <= 1'b1;
        vram_addr  <= tile_addr;
        vram_data  <= p_color;
        all_issued <= last_col && last_row;
        if (last_col) begin
          col  <= 6'd0;
          row  <= p_row + 5'd1;
          base <= p_base + COLS_A;
        end else begin
          col  <= p_col + 6'd1;
          row  <= p_row;
          base <= p_base;
        end
      end
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: directed self-checking bench for rect_fill_engine.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_rect_fill_engine;

  logic        sys_clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_x = '0;
  logic [4:0]  cmd_y = '0;
  logic [5:0]  cmd_w = '0;
  logic [4:0]  cmd_h = '0;
  logic [1:0]  cmd_color = '0;
  logic        cmd_vblank_only = 1'b0;
  logic        vsync_ready = 1'b0;
  logic        vram_we;
  logic [10:0] vram_addr;
  logic [1:0]  vram_data;
  logic        busy;
  logic        done;

  rect_fill_engine #(
    .COLS          (40),
    .ROWS          (30),
    .WINDOW_CYCLES (4)
  ) dut (
    .sys_clock       (sys_clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_x           (cmd_x),
    .cmd_y           (cmd_y),
    .cmd_w           (cmd_w),
    .cmd_h           (cmd_h),
    .cmd_color       (cmd_color),
    .cmd_vblank_only (cmd_vblank_only),
    .vsync_ready     (vsync_ready),
    .vram_we         (vram_we),
    .vram_addr       (vram_addr),
    .vram_data       (vram_data),
    .busy            (busy),
    .done            (done)
  );

  always #5 sys_clock = ~sys_clock;

  int cyc = 0;
  always @(posedge sys_clock) cyc <= cyc + 1;

  // Write/done log sampled mid-cycle
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cyc[$];

  always @(negedge sys_clock) begin
    if (vram_we === 1'b1) begin
      wr_addr.push_back(int'(vram_addr));
      wr_data.push_back(int'(vram_data));
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;
  int hs = 0;
  int p = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic send(input int x, input int y, input int w, input int h, input int c,
                      input bit vb, input bit keep);
    @(negedge sys_clock);
    cmd_x           = 6'(x);
    cmd_y           = 5'(y);
    cmd_w           = 6'(w);
    cmd_h           = 5'(h);
    cmd_color       = 2'(c);
    cmd_vblank_only = vb;
    cmd_valid       = 1'b1;
    for (int n = 0; n < 200 && cmd_ready !== 1'b1; n++) @(negedge sys_clock);
    if (cmd_ready !== 1'b1) check("send_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge sys_clock);
    #1;
    hs = cyc;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic vsync_pulse();
    @(negedge sys_clock);
    vsync_ready = 1'b1;
    @(posedge sys_clock);
    #1;
    p = cyc;
    @(negedge sys_clock);
    vsync_ready = 1'b0;
    repeat (8) @(negedge sys_clock);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clock);
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_addr", 32'(vram_addr), 32'd0);
    check("rst_data", 32'(vram_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge sys_clock);
    reset = 1'b1;
    repeat (2) @(negedge sys_clock);

    // 4x2 at (2,3), colour 1
    clear_log();
    send(2, 3, 4, 2, 1, 1'b0, 1'b0);
    repeat (12) @(negedge sys_clock);
    check("basic_count", 32'(wr_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wr_addr.size()) begin
        check("basic_addr", 32'(wr_addr[i]), 32'((i < 4) ? 122 + i : 158 + i));
        check("basic_data", 32'(wr_data[i]), 32'd1);
        check("basic_cyc", 32'(wr_cyc[i]), 32'(hs + i));
      end
    end
    check("basic_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("basic_done_cyc", 32'(done_cyc[0]), 32'(hs + 8));

    // Clipped at the bottom-right corner
    clear_log();
    send(38, 29, 5, 4, 3, 1'b0, 1'b0);
    repeat (8) @(negedge sys_clock);
    check("clip_count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("clip_addr0", 32'(wr_addr[0]), 32'd1198);
      check("clip_addr1", 32'(wr_addr[1]), 32'd1199);
      check("clip_data", 32'(wr_data[1]), 32'd3);
    end
    if (done_cyc.size() > 0) check("clip_done_cyc", 32'(done_cyc[0]), 32'(hs + 2));

    // Zero width
    clear_log();
    send(5, 5, 0, 3, 1, 1'b0, 1'b0);
    repeat (6) @(negedge sys_clock);
    check("w0_count", 32'(wr_addr.size()), 32'd0);
    check("w0_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("w0_done_cyc", 32'(done_cyc[0]), 32'(hs + 1));

    // Off-screen column
    clear_log();
    send(40, 0, 3, 3, 2, 1'b0, 1'b0);
    repeat (6) @(negedge sys_clock);
    check("x40_count", 32'(wr_addr.size()), 32'd0);
    check("x40_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("x40_done_cyc", 32'(done_cyc[0]), 32'(hs + 1));

    // cmd_valid held through a fill: second acceptance only after done
    clear_log();
    send(0, 0, 2, 1, 2, 1'b0, 1'b1);
    p = hs;
    repeat (5) @(negedge sys_clock);
    cmd_valid = 1'b0;
    repeat (10) @(negedge sys_clock);
    check("hold_count", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) begin
      check("hold_cyc1", 32'(wr_cyc[1]), 32'(p + 1));
      check("hold_cyc2", 32'(wr_cyc[2]), 32'(p + 4));
      check("hold_addr2", 32'(wr_addr[2]), 32'd0);
    end
    check("hold_done_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() > 0) check("hold_done_cyc", 32'(done_cyc[0]), 32'(p + 2));

    // Reset mid-fill after the third write
    clear_log();
    send(0, 0, 4, 4, 1, 1'b0, 1'b0);
    repeat (3) @(negedge sys_clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_we", 32'(vram_we), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_writes_before", 32'(wr_addr.size()), 32'd3);
    repeat (2) @(negedge sys_clock);
    reset = 1'b1;
    clear_log();
    repeat (10) @(negedge sys_clock);
    check("abort_writes_after", 32'(wr_addr.size()), 32'd0);
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    check("abort_done_after", 32'(done_cyc.size()), 32'd0);

    // Vblank-only fill of 10 tiles with a 4-cycle window
    clear_log();
    send(0, 0, 10, 1, 2, 1'b1, 1'b0);
    repeat (6) @(negedge sys_clock);
    check("vb_no_early_writes", 32'(wr_addr.size()), 32'd0);
    check("vb_busy_waiting", 32'(busy), 32'd1);
    vsync_pulse();
    check("vb_p1_count", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) begin
      check("vb_p1_cyc0", 32'(wr_cyc[0]), 32'(p + 1));
      check("vb_p1_cyc3", 32'(wr_cyc[3]), 32'(p + 4));
      check("vb_p1_addr3", 32'(wr_addr[3]), 32'd3);
    end
    check("vb_p1_no_done", 32'(done_cyc.size()), 32'd0);
    vsync_pulse();
    check("vb_p2_count", 32'(wr_addr.size()), 32'd8);
    if (wr_addr.size() == 8) begin
      check("vb_p2_addr4", 32'(wr_addr[4]), 32'd4);
      check("vb_p2_cyc4", 32'(wr_cyc[4]), 32'(p + 1));
      check("vb_p2_addr7", 32'(wr_addr[7]), 32'd7);
    end
    vsync_pulse();
    check("vb_p3_count", 32'(wr_addr.size()), 32'd10);
    if (wr_addr.size() == 10) begin
      check("vb_last_addr", 32'(wr_addr[9]), 32'd9);
      check("vb_last_data", 32'(wr_data[9]), 32'd2);
      check("vb_last_cyc", 32'(wr_cyc[9]), 32'(p + 2));
    end
    check("vb_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("vb_done_cyc", 32'(done_cyc[0]), 32'(p + 3));
    check("vb_idle_ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SHALL have parameter COLS, default 40: tile columns.
REQ-002 SHALL have parameter ROWS, default 30: tile rows.
REQ-003 SHALL have parameter WINDOW_CYCLES, default 16384: sys_clock cycles writes stay allowed after each vsync_ready pulse.
REQ-004 SHALL have port sys_clock  input  1  system clock, 100 MHz; only clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  engine accepts a command.
REQ-008 SHALL have port cmd_x  input  6  left tile column.
REQ-009 SHALL have port cmd_y  input  5  top tile row.
REQ-010 SHALL have port cmd_w  input  6  width in tiles.
REQ-011 SHALL have port cmd_h  input  5  height in tiles.
REQ-012 SHALL have port cmd_color  input  2  palette index.
REQ-013 SHALL have port cmd_vblank_only  input  1  restrict writes to the blanking window.
REQ-014 SHALL have port vsync_ready  input  1  one-cycle vertical-blank pulse from vga_controller.
REQ-015 SHALL have port vram_we  output  1  to vga_controller cpu_we.
REQ-016 SHALL have port vram_addr  output  11  to cpu_addr, range 0..COLS*ROWS-1.
REQ-017 SHALL have port vram_data  output  2  to cpu_data.
REQ-018 SHALL have port busy  output  1  command in progress.
REQ-019 SHALL have port done  output  1  one-cycle pulse when a command completes.

Function
REQ-020 SHALL implement FSM states IDLE, FILL, WAIT_WIN and FINISH.
REQ-021 SHALL drive cmd_ready high only in IDLE; handshake is cmd_valid && cmd_ready on a rising edge; all cmd_* fields are latched at the handshake.
REQ-022 SHALL clip to the screen: cw = min(cmd_x+cmd_w, COLS) - cmd_x and ch = min(cmd_y+cmd_h, ROWS) - cmd_y, computed at widths that cannot overflow.
REQ-023 SHALL go IDLE->FINISH with no write when cw==0, ch==0, cmd_x>=COLS or cmd_y>=ROWS.
REQ-024 SHALL otherwise go IDLE->FILL, or IDLE->WAIT_WIN when cmd_vblank_only is set and the window is closed.
REQ-025 SHALL, in FILL, issue exactly one write per cycle in row-major order: vram_we=1, vram_addr=row_base+col, vram_data=latched color.
REQ-026 SHALL advance row_base by COLS per row using an adder, with no multiplier; the initial row_base is cmd_y*COLS, built from shifts and adds.
REQ-027 SHALL, when not in vblank-only mode, assert the first vram_we in the cycle after the handshake; total writes = cw*ch.
REQ-028 SHALL, in vblank-only mode, go FILL->WAIT_WIN when the window closes before the last write, then WAIT_WIN->FILL when the window reopens, resuming at the next unwritten tile with no tile skipped or repeated.
REQ-029 SHALL go FILL->FINISH after the last write; in FINISH, done=1 for exactly one cycle, then the state returns to IDLE.
REQ-030 SHALL drive busy high in FILL, WAIT_WIN and FINISH.
REQ-031 SHALL register vram_we, vram_addr, vram_data and done; vram_we SHALL be 0 outside FILL.
REQ-032 SHALL run the window counter: load WINDOW_CYCLES on vsync_ready, otherwise decrement while nonzero; window open = counter!=0.
REQ-033 SHALL run the window counter in all states; a vsync_ready pulse during an open window reloads the counter.
REQ-034 SHALL ignore cmd_valid while busy.

Reset
REQ-035 SHALL, on reset low, immediately set state=IDLE, vram_we=0, vram_addr=0, vram_data=0, done=0, busy=0, window counter=0 and cmd_ready=1.
REQ-036 SHALL abort any in-progress fill on reset mid-operation, with no further writes after reset deasserts until a new handshake.

Structure
REQ-037 SHALL take COLS, ROWS, VRAM depth 1200, the 11-bit address typedef, the 2-bit color typedef and the FSM state enum from the shared package vga_pkg.
REQ-038 SHALL implement the window counter as sub-module vblank_window_timer (sys_clock, reset, vsync_ready -> window_open).

Verification
REQ-039 SHALL cover: cmd x=2,y=3,w=4,h=2,color=1, vblank_only=0 -> 8 writes on consecutive cycles, addr 122..125 then 162..165, data=1; done one cycle after addr 165.
REQ-040 SHALL cover: x=38,y=29,w=5,h=4 -> clipped to 2x1; writes addr 1198, 1199 only.
REQ-041 SHALL cover: w=0, or x=40 -> no vram_we; done pulses 2 cycles after the handshake.
REQ-042 SHALL cover: WINDOW_CYCLES=4, vblank_only=1, 0,0,10,1 -> no writes before vsync_ready; 4 writes (addr 0..3) per pulse; completes after 3 pulses, last addr 9.
REQ-043 SHALL cover: reset low after the 3rd write of a 4x4 fill -> vram_we=0 immediately; cmd_ready=1 and no writes after release.
REQ-044 SHALL cover: cmd_valid held high during a fill -> second command accepted only after done, in IDLE.
